// File: rtl/booth_radix4_encoder.sv
// Sequential radix-4 Booth recoder: accepts one multiplier word, then streams one
// {neg, mag[1:0]} digit per beat, LSB digit first. Macro BOOTH_ENC_UNSIGNED_EN selects unsigned operands.
module booth_radix4_encoder #(
  parameter int WIDTH = 16,
`ifdef BOOTH_ENC_UNSIGNED_EN
  localparam int DIGITS = WIDTH/2 + 1,
  localparam int SR_W   = WIDTH + 3,
`else
  localparam int DIGITS = WIDTH/2,
  localparam int SR_W   = WIDTH + 1,
`endif
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mult_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       enc_out,
  output logic [IDX_W-1:0] digit_idx,
  output logic             out_last
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d, sr_load, sr_shift;
  logic [IDX_W-1:0]  cnt_q, cnt_d;

  function automatic logic [2:0] booth_code(input logic [2:0] b);
    case (b)
      3'b001, 3'b010: booth_code = 3'b001;
      3'b011:         booth_code = 3'b010;
      3'b100:         booth_code = 3'b110;
      3'b101, 3'b110: booth_code = 3'b101;
      default:        booth_code = 3'b000;
    endcase
  endfunction

  // Unsigned mode zero-extends by two bits so the extra top digit is never negative.
`ifdef BOOTH_ENC_UNSIGNED_EN
  assign sr_load  = {2'b00, mult_in, 1'b0};
  assign sr_shift = {2'b00, sr_q[SR_W-1:2]};
`else
  assign sr_load  = {mult_in, 1'b0};
  assign sr_shift = {{2{sr_q[SR_W-1]}}, sr_q[SR_W-1:2]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    enc_out   = 3'b000;
    digit_idx = '0;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sr_d    = sr_load;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        enc_out   = booth_code(sr_q[2:0]);
        digit_idx = cnt_q;
        out_last  = (cnt_q == LAST);
        if (out_ready) begin
          sr_d = sr_shift;
          // Counter wraps to zero on the final beat so IDLE always sees a clean count.
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
